// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S parameterised datapath:
// decoded instruction set, opcode values, ALU modes and the opcode decoder.
package k_and_s_pkg;

   typedef enum logic [4:0] {
      I_NOP    = 5'd0,
      I_LOAD   = 5'd1,
      I_STORE  = 5'd2,
      I_MOVE   = 5'd3,
      I_ADD    = 5'd4,
      I_SUB    = 5'd5,
      I_AND    = 5'd6,
      I_OR     = 5'd7,
      I_SHL    = 5'd8,
      I_SHR    = 5'd9,
      I_BRANCH = 5'd10,
      I_BZERO  = 5'd11,
      I_BNEG   = 5'd12,
      I_BOV    = 5'd13,
      I_BNOV   = 5'd14,
      I_BNNEG  = 5'd15,
      I_BNZERO = 5'd16,
      I_HALT   = 5'd17
   } decoded_instruction_type;

   localparam logic [7:0] OPC_LOAD   = 8'h81;
   localparam logic [7:0] OPC_STORE  = 8'h82;
   localparam logic [7:0] OPC_MOVE   = 8'h91;
   localparam logic [7:0] OPC_ADD    = 8'hA1;
   localparam logic [7:0] OPC_SUB    = 8'hA2;
   localparam logic [7:0] OPC_AND    = 8'hA3;
   localparam logic [7:0] OPC_OR     = 8'hA4;
   localparam logic [7:0] OPC_SHL    = 8'hA5;
   localparam logic [7:0] OPC_SHR    = 8'hA6;
   localparam logic [7:0] OPC_BRANCH = 8'h01;
   localparam logic [7:0] OPC_BZERO  = 8'h02;
   localparam logic [7:0] OPC_BNEG   = 8'h03;
   localparam logic [7:0] OPC_BOV    = 8'h05;
   localparam logic [7:0] OPC_BNOV   = 8'h06;
   localparam logic [7:0] OPC_BNNEG  = 8'h0A;
   localparam logic [7:0] OPC_BNZERO = 8'h0B;
   localparam logic [7:0] OPC_HALT   = 8'hFF;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'b000,
      ALU_SUB   = 3'b001,
      ALU_AND   = 3'b010,
      ALU_OR    = 3'b011,
      ALU_SHL   = 3'b100,
      ALU_SHR   = 3'b101,
      ALU_PASS  = 3'b110,
      ALU_PASS2 = 3'b111
   } alu_mode_t;

   // Field layout class of an instruction; selects which IR fields are live.
   typedef enum logic [2:0] {
      FMT_NONE   = 3'd0,
      FMT_LOAD   = 3'd1,
      FMT_STORE  = 3'd2,
      FMT_MOVE   = 3'd3,
      FMT_ALU    = 3'd4,
      FMT_BRANCH = 3'd5
   } instr_fmt_t;

   function automatic decoded_instruction_type decode_opcode(input logic [7:0] opc);
      decoded_instruction_type d;
      case (opc)
         OPC_LOAD:   d = I_LOAD;
         OPC_STORE:  d = I_STORE;
         OPC_MOVE:   d = I_MOVE;
         OPC_ADD:    d = I_ADD;
         OPC_SUB:    d = I_SUB;
         OPC_AND:    d = I_AND;
         OPC_OR:     d = I_OR;
         OPC_SHL:    d = I_SHL;
         OPC_SHR:    d = I_SHR;
         OPC_BRANCH: d = I_BRANCH;
         OPC_BZERO:  d = I_BZERO;
         OPC_BNEG:   d = I_BNEG;
         OPC_BOV:    d = I_BOV;
         OPC_BNOV:   d = I_BNOV;
         OPC_BNNEG:  d = I_BNNEG;
         OPC_BNZERO: d = I_BNZERO;
         OPC_HALT:   d = I_HALT;
         default:    d = I_NOP;
      endcase
      return d;
   endfunction

   function automatic instr_fmt_t format_of(input decoded_instruction_type d);
      instr_fmt_t f;
      case (d)
         I_LOAD:                                    f = FMT_LOAD;
         I_STORE:                                   f = FMT_STORE;
         I_MOVE:                                    f = FMT_MOVE;
         I_ADD, I_SUB, I_AND, I_OR, I_SHL, I_SHR:   f = FMT_ALU;
         I_BRANCH, I_BZERO, I_BNEG, I_BOV,
         I_BNOV, I_BNNEG, I_BNZERO:                 f = FMT_BRANCH;
         default:                                   f = FMT_NONE;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/ks_param_data_path_if.sv
// Control-unit strobe bundle driving the datapath.
interface ks_param_data_path_if;
   logic       branch;
   logic       pc_enable;
   logic       ir_enable;
   logic       addr_sel;
   logic       c_sel;
   logic       write_reg_enable;
   logic       flags_reg_enable;
   logic [2:0] operation;

   modport master (
      output branch, pc_enable, ir_enable, addr_sel, c_sel,
             write_reg_enable, flags_reg_enable, operation
   );

   modport slave (
      input  branch, pc_enable, ir_enable, addr_sel, c_sel,
             write_reg_enable, flags_reg_enable, operation
   );
endinterface

// File: rtl/ks_regfile.sv
// Register file: NREG x DATA_W, two combinational read ports, one
// synchronous write port. A same-cycle read of the written entry sees the
// old contents because the write only lands at the clock edge.
module ks_regfile #(
   parameter int DATA_W = 16,
   parameter int NREG   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [$clog2(NREG)-1:0] waddr,
   input  logic [DATA_W-1:0]       wdata,
   input  logic [$clog2(NREG)-1:0] raddr_a,
   input  logic [$clog2(NREG)-1:0] raddr_b,
   output logic [DATA_W-1:0]       rdata_a,
   output logic [DATA_W-1:0]       rdata_b
);

   logic [DATA_W-1:0] regs_r [NREG];

   // Storage update: synchronous clear, otherwise write on enable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_r[i] <= '0;
         end
      end else if (we) begin
         regs_r[waddr] <= wdata;
      end
   end

   assign rdata_a = regs_r[raddr_a];
   assign rdata_b = regs_r[raddr_b];

endmodule

// File: rtl/ks_param_data_path.sv
// K&S datapath: IR, PC, instruction decode, register file, ALU and flag
// registers, steered by strobes from the control unit.
module ks_param_data_path
   import k_and_s_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 5,
   parameter int NREG   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ks_param_data_path_if.slave     ctrl,
   input  logic [DATA_W-1:0]       data_in,
   output decoded_instruction_type decoded_instruction,
   output logic                    zero_op,
   output logic                    neg_op,
   output logic                    unsigned_overflow,
   output logic                    signed_overflow,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [DATA_W-1:0]       data_out
);

   localparam int RW = $clog2(NREG);

   // Field widths must fit below the 8-bit opcode.
   if (DATA_W < 16 || ADDR_W < 1 || NREG < 2 || NREG > 16 ||
       (NREG & (NREG - 1)) != 0 ||
       DATA_W < 8 + ADDR_W + RW || DATA_W < 8 + 3 * RW) begin : g_param_check
      $error("ks_param_data_path: illegal DATA_W/ADDR_W/NREG combination");
   end

   logic [DATA_W-1:0] ir_r;
   logic [ADDR_W-1:0] pc_r;
   logic [7:0]        opcode_s;
   instr_fmt_t        fmt_s;
   logic [ADDR_W-1:0] dec_addr_s;
   logic [RW-1:0]     dst_s;
   logic [RW-1:0]     rd_a_s;
   logic [RW-1:0]     rd_b_s;
   logic [DATA_W-1:0] bus_a_s;
   logic [DATA_W-1:0] bus_b_s;
   logic [DATA_W-1:0] wdata_s;
   logic [DATA_W:0]   ext_s;
   logic [DATA_W-1:0] alu_res_s;
   logic              alu_uov_s;
   logic              alu_sov_s;
   logic              alu_zero_s;
   logic              alu_neg_s;
   logic              unused_ir_s;

   assign opcode_s    = ir_r[DATA_W-1 -: 8];
   assign unused_ir_s = ^ir_r;

   // Opcode decode and field extraction; fields not used by the format stay 0.
   always_comb begin
      decoded_instruction = decode_opcode(opcode_s);
      fmt_s               = format_of(decoded_instruction);
      dec_addr_s          = '0;
      dst_s               = '0;
      rd_a_s              = '0;
      rd_b_s              = '0;
      case (fmt_s)
         FMT_LOAD: begin
            dst_s      = ir_r[ADDR_W +: RW];
            dec_addr_s = ir_r[ADDR_W-1:0];
         end
         FMT_STORE: begin
            rd_a_s     = ir_r[ADDR_W +: RW];
            dec_addr_s = ir_r[ADDR_W-1:0];
         end
         FMT_MOVE: begin
            dst_s  = ir_r[RW +: RW];
            rd_a_s = ir_r[0 +: RW];
         end
         FMT_ALU: begin
            dst_s  = ir_r[2*RW +: RW];
            rd_a_s = ir_r[RW +: RW];
            rd_b_s = ir_r[0 +: RW];
         end
         FMT_BRANCH: begin
            dec_addr_s = ir_r[ADDR_W-1:0];
         end
         default: begin
            dec_addr_s = '0;
         end
      endcase
   end

   assign wdata_s = ctrl.c_sel ? data_in : alu_res_s;

   ks_regfile #(
      .DATA_W (DATA_W),
      .NREG   (NREG)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (ctrl.write_reg_enable),
      .waddr   (dst_s),
      .wdata   (wdata_s),
      .raddr_a (rd_a_s),
      .raddr_b (rd_b_s),
      .rdata_a (bus_a_s),
      .rdata_b (bus_b_s)
   );

   // ALU result plus carry/borrow/shift-out and signed overflow.
   always_comb begin
      ext_s     = '0;
      alu_res_s = bus_a_s;
      alu_uov_s = 1'b0;
      alu_sov_s = 1'b0;
      case (alu_mode_t'(ctrl.operation))
         ALU_ADD: begin
            ext_s     = {1'b0, bus_a_s} + {1'b0, bus_b_s};
            alu_res_s = ext_s[DATA_W-1:0];
            alu_uov_s = ext_s[DATA_W];
            alu_sov_s = (bus_a_s[DATA_W-1] == bus_b_s[DATA_W-1]) &&
                        (alu_res_s[DATA_W-1] != bus_a_s[DATA_W-1]);
         end
         ALU_SUB: begin
            ext_s     = {1'b0, bus_a_s} - {1'b0, bus_b_s};
            alu_res_s = ext_s[DATA_W-1:0];
            alu_uov_s = ext_s[DATA_W];
            alu_sov_s = (bus_a_s[DATA_W-1] != bus_b_s[DATA_W-1]) &&
                        (alu_res_s[DATA_W-1] != bus_a_s[DATA_W-1]);
         end
         ALU_AND: alu_res_s = bus_a_s & bus_b_s;
         ALU_OR:  alu_res_s = bus_a_s | bus_b_s;
         ALU_SHL: begin
            alu_res_s = {bus_a_s[DATA_W-2:0], 1'b0};
            alu_uov_s = bus_a_s[DATA_W-1];
         end
         ALU_SHR: begin
            alu_res_s = {1'b0, bus_a_s[DATA_W-1:1]};
            alu_uov_s = bus_a_s[0];
         end
         default: alu_res_s = bus_a_s;
      endcase
   end

   assign alu_zero_s = (alu_res_s == '0);
   assign alu_neg_s  = alu_res_s[DATA_W-1];

   // Instruction register load.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ir_r <= '0;
      end else if (ctrl.ir_enable) begin
         ir_r <= data_in;
      end
   end

   // Program counter: branch target or wrap-around increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_r <= '0;
      end else if (ctrl.pc_enable) begin
         if (ctrl.branch) begin
            pc_r <= dec_addr_s;
         end else begin
            pc_r <= pc_r + {{(ADDR_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Flag registers capture the ALU flags when enabled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         zero_op           <= 1'b0;
         neg_op            <= 1'b0;
         unsigned_overflow <= 1'b0;
         signed_overflow   <= 1'b0;
      end else if (ctrl.flags_reg_enable) begin
         zero_op           <= alu_zero_s;
         neg_op            <= alu_neg_s;
         unsigned_overflow <= alu_uov_s;
         signed_overflow   <= alu_sov_s;
      end
   end

   assign ram_addr = ctrl.addr_sel ? dec_addr_s : pc_r;
   assign data_out = bus_a_s;

endmodule

// File: tb/tb_ks_param_data_path.sv
// Bench for ks_param_data_path: a 16-bit default instance exercised by an
// ALU vector table and hand-written sequences, and a 32-bit/8-register
// instance for the wide LOAD/MOVE/STORE path. Expected values go through a
// scoreboard queue and are compared after the DUT edge.
module tb_ks_param_data_path;
   import k_and_s_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   ks_param_data_path_if c0();
   logic [15:0] din0;
   decoded_instruction_type dec0;
   logic fz0, fn0, fu0, fs0;
   logic [4:0] addr0;
   logic [15:0] dout0;

   ks_param_data_path_if c1();
   logic [31:0] din1;
   decoded_instruction_type dec1;
   logic fz1, fn1, fu1, fs1;
   logic [7:0] addr1;
   logic [31:0] dout1;

   ks_param_data_path #(.DATA_W(16), .ADDR_W(5), .NREG(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .ctrl(c0), .data_in(din0),
      .decoded_instruction(dec0), .zero_op(fz0), .neg_op(fn0),
      .unsigned_overflow(fu0), .signed_overflow(fs0),
      .ram_addr(addr0), .data_out(dout0)
   );

   ks_param_data_path #(.DATA_W(32), .ADDR_W(8), .NREG(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .ctrl(c1), .data_in(din1),
      .decoded_instruction(dec1), .zero_op(fz1), .neg_op(fn1),
      .unsigned_overflow(fu1), .signed_overflow(fs1),
      .ram_addr(addr1), .data_out(dout1)
   );

   int n_vec  = 0;
   int n_miss = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic [7:0]              opc;
      logic [2:0]              mode;
      logic [15:0]             a;
      logic [15:0]             b;
      logic [15:0]             res;
      logic [3:0]              flags;   // {zero, neg, unsigned_ov, signed_ov}
      decoded_instruction_type dec;
   } vec_t;
   vec_t vt[10];

   task automatic sb_push(input string nm, input logic [31:0] e);
      sb_t t;
      t.name = nm;
      t.exp  = e;
      sb_q.push_back(t);
   endtask

   task automatic sb_check(input logic [31:0] act);
      sb_t t;
      n_vec++;
      if (sb_q.size() == 0) begin
         n_miss++;
         $display("FAIL scoreboard_empty actual=0x%0h", act);
      end else begin
         t = sb_q.pop_front();
         if (act !== t.exp) begin
            n_miss++;
            $display("FAIL %s actual=0x%0h required=0x%0h", t.name, act, t.exp);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle0();
      c0.branch = 1'b0; c0.pc_enable = 1'b0; c0.ir_enable = 1'b0;
      c0.addr_sel = 1'b0; c0.c_sel = 1'b0; c0.write_reg_enable = 1'b0;
      c0.flags_reg_enable = 1'b0; c0.operation = 3'b000;
   endtask

   task automatic idle1();
      c1.branch = 1'b0; c1.pc_enable = 1'b0; c1.ir_enable = 1'b0;
      c1.addr_sel = 1'b0; c1.c_sel = 1'b0; c1.write_reg_enable = 1'b0;
      c1.flags_reg_enable = 1'b0; c1.operation = 3'b000;
   endtask

   function automatic logic [15:0] mk_ls(input logic [7:0] opc, input int r, input int a);
      return {opc, 8'h00} | 16'((r & 3) << 5) | 16'(a & 31);
   endfunction

   function automatic logic [15:0] mk_alu(input logic [7:0] opc, input int d, input int x, input int y);
      return {opc, 8'h00} | 16'((d & 3) << 4) | 16'((x & 3) << 2) | 16'(y & 3);
   endfunction

   task automatic load_ir0(input logic [15:0] instr);
      din0 = instr;
      c0.ir_enable = 1'b1;
      step();
      c0.ir_enable = 1'b0;
   endtask

   task automatic wr_reg0(input int r, input logic [15:0] v);
      load_ir0(mk_ls(OPC_LOAD, r, 0));
      din0 = v;
      c0.c_sel = 1'b1;
      c0.write_reg_enable = 1'b1;
      step();
      c0.c_sel = 1'b0;
      c0.write_reg_enable = 1'b0;
   endtask

   task automatic rd_reg_check0(input int r, input logic [15:0] e, input string nm);
      load_ir0(mk_ls(OPC_STORE, r, 0));
      sb_push(nm, 32'(e));
      sb_check(32'(dout0));
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0] = '{OPC_ADD, 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101, I_ADD};
      vt[1] = '{OPC_SUB, 3'b001, 16'h0001, 16'h0002, 16'hFFFF, 4'b0110, I_SUB};
      vt[2] = '{OPC_SUB, 3'b001, 16'h0005, 16'h0005, 16'h0000, 4'b1000, I_SUB};
      vt[3] = '{OPC_SHL, 3'b100, 16'h8001, 16'h0000, 16'h0002, 4'b0010, I_SHL};
      vt[4] = '{OPC_SHR, 3'b101, 16'h0001, 16'h0000, 16'h0000, 4'b1010, I_SHR};
      vt[5] = '{OPC_ADD, 3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010, I_ADD};
      vt[6] = '{OPC_AND, 3'b010, 16'hF0F0, 16'h3C3C, 16'h3030, 4'b0000, I_AND};
      vt[7] = '{OPC_OR,  3'b011, 16'h8000, 16'h0001, 16'h8001, 4'b0100, I_OR};
      vt[8] = '{OPC_SUB, 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0001, I_SUB};
      vt[9] = '{OPC_ADD, 3'b110, 16'h1234, 16'h5555, 16'h1234, 4'b0000, I_ADD};

      idle0(); idle1();
      din0 = 16'h0000; din1 = 32'h0;
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;

      // Dirty every piece of state, then reset with all enables high.
      wr_reg0(0, 16'h1111); wr_reg0(1, 16'h8000); wr_reg0(2, 16'h8000);
      load_ir0(mk_alu(OPC_ADD, 3, 1, 2));
      c0.operation = 3'b000; c0.write_reg_enable = 1'b1; c0.flags_reg_enable = 1'b1;
      step(); idle0();
      wr_reg0(3, 16'h4444); wr_reg0(1, 16'h2222);
      c0.pc_enable = 1'b1;
      step(); step(); step();
      idle0();
      load_ir0(mk_ls(OPC_LOAD, 2, 5));
      rst_n = 1'b0;
      din0 = 16'hAAAA;
      c0.branch = 1'b1; c0.pc_enable = 1'b1; c0.ir_enable = 1'b1; c0.c_sel = 1'b1;
      c0.write_reg_enable = 1'b1; c0.flags_reg_enable = 1'b1;
      step();
      rst_n = 1'b1;
      idle0();
      sb_push("rst_decoded", 32'(I_NOP));     sb_check(32'(dec0));
      sb_push("rst_ram_addr", 32'h0);         sb_check(32'(addr0));
      sb_push("rst_data_out", 32'h0);         sb_check(32'(dout0));
      sb_push("rst_flags", 32'h0);            sb_check(32'({fz0, fn0, fu0, fs0}));
      for (int r = 0; r < 4; r++) begin
         rd_reg_check0(r, 16'h0000, $sformatf("rst_R%0d", r));
      end

      // ALU vector table.
      for (int i = 0; i < 10; i++) begin
         wr_reg0(1, vt[i].a);
         wr_reg0(2, vt[i].b);
         load_ir0(mk_alu(vt[i].opc, 3, 1, 2));
         sb_push($sformatf("v%0d_decoded", i), 32'(vt[i].dec));
         sb_check(32'(dec0));
         c0.operation = vt[i].mode;
         c0.write_reg_enable = 1'b1;
         c0.flags_reg_enable = 1'b1;
         sb_push($sformatf("v%0d_flags", i), 32'(vt[i].flags));
         step();
         idle0();
         sb_check(32'({fz0, fn0, fu0, fs0}));
         rd_reg_check0(3, vt[i].res, $sformatf("v%0d_result", i));
      end

      // PC: decoded-address select, branch to 31, wrap, branch to 10, hold.
      load_ir0(mk_ls(OPC_BRANCH, 0, 31));
      c0.addr_sel = 1'b1; #1;
      sb_push("addr_sel_decoded", 32'd31);    sb_check(32'(addr0));
      c0.addr_sel = 1'b0; #1;
      sb_push("pc_after_reset", 32'd0);       sb_check(32'(addr0));
      c0.pc_enable = 1'b1; c0.branch = 1'b1;
      step(); idle0();
      sb_push("pc_branch_31", 32'd31);        sb_check(32'(addr0));
      c0.pc_enable = 1'b1;
      step(); idle0();
      sb_push("pc_wrap", 32'd0);              sb_check(32'(addr0));
      load_ir0(mk_ls(OPC_BRANCH, 0, 10));
      sb_push("branch_decoded", 32'(I_BRANCH)); sb_check(32'(dec0));
      c0.pc_enable = 1'b1; c0.branch = 1'b1;
      step(); idle0();
      sb_push("pc_branch_10", 32'd10);        sb_check(32'(addr0));
      load_ir0(mk_ls(OPC_BNNEG, 0, 3));
      c0.branch = 1'b1;
      step(); idle0();
      sb_push("pc_hold", 32'd10);             sb_check(32'(addr0));

      // All enables on one edge, each using pre-edge state.
      wr_reg0(1, 16'hFFFF);
      wr_reg0(2, 16'h0002);
      load_ir0(mk_alu(OPC_ADD, 3, 1, 2));
      din0 = mk_ls(OPC_STORE, 3, 0);
      c0.ir_enable = 1'b1; c0.write_reg_enable = 1'b1; c0.flags_reg_enable = 1'b1;
      c0.pc_enable = 1'b1; c0.operation = 3'b000;
      step(); idle0();
      sb_push("simul_R3", 32'h0001);          sb_check(32'(dout0));
      sb_push("simul_flags", 32'b0010);       sb_check(32'({fz0, fn0, fu0, fs0}));
      sb_push("simul_pc", 32'd11);            sb_check(32'(addr0));
      sb_push("simul_decoded", 32'(I_STORE)); sb_check(32'(dec0));

      // Unknown opcode decodes to NOP with zeroed fields.
      load_ir0(16'h7F3F);
      sb_push("unknown_decoded", 32'(I_NOP)); sb_check(32'(dec0));
      c0.addr_sel = 1'b1; #1;
      sb_push("unknown_addr", 32'd0);         sb_check(32'(addr0));
      c0.addr_sel = 1'b0;

      // Wide instance: LOAD R7 @0x40, MOVE R7->R5, STORE R5 @0x40.
      sb_push("w_rst_decoded", 32'(I_NOP));   sb_check(32'(dec1));
      din1 = 32'h8100_0740;
      c1.ir_enable = 1'b1;
      step(); idle1();
      c1.addr_sel = 1'b1; #1;
      sb_push("w_load_addr", 32'h40);         sb_check(32'(addr1));
      din1 = 32'hDEAD_BEEF;
      c1.c_sel = 1'b1; c1.write_reg_enable = 1'b1;
      step(); idle1();
      din1 = 32'h9100_002F;
      c1.ir_enable = 1'b1;
      step(); idle1();
      sb_push("w_move_decoded", 32'(I_MOVE)); sb_check(32'(dec1));
      c1.operation = 3'b110; c1.write_reg_enable = 1'b1;
      step(); idle1();
      din1 = 32'h8200_0540;
      c1.ir_enable = 1'b1;
      step(); idle1();
      c1.addr_sel = 1'b1; #1;
      sb_push("w_store_data", 32'hDEAD_BEEF); sb_check(dout1);
      sb_push("w_store_addr", 32'h40);        sb_check(32'(addr1));
      idle1();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
